sseg_scan_ctrl: RTL and testbench

Sequential front end for the 4-digit TDM seven-segment display path. Generates the rotating digit_sel that the downstream display decoder consumes. Holds the data/hex_dec/sign word that is shown, and accepts new display words over a valid/ready handshake. New words are applied only at a frame boundary, so a refresh frame never shows a mix of old and new digits.

---
 rtl/sseg_pkg.sv | 10 +
 rtl/sseg_scan_ctrl_refresh_counter.sv | 26 ++
 rtl/sseg_scan_ctrl.sv | 74 +++++++
 tb/tb_sseg_scan_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types for the seven-segment scan front end.
package sseg_pkg;
    localparam int DIGITS = 4;
    typedef logic [1:0] digit_sel_t;
    typedef struct packed {
        logic [15:0] data;
        logic        hex_dec;
        logic        sign;
    } disp_word_t;
endpackage

// File: rtl/sseg_scan_ctrl_refresh_counter.sv
// refresh_counter: tick and digit counters, with the per-digit wrap strobe and the frame boundary.
module refresh_counter
    import sseg_pkg::*;
#(
    parameter int TICKS = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output digit_sel_t digit_sel,
    output logic       wrap,
    output logic       fb
);
    localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    logic [CNT_W-1:0] tick_cnt;
    assign wrap = tick_cnt == CNT_W'(TICKS - 1);
    assign fb = wrap && digit_sel == digit_sel_t'(DIGITS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            digit_sel <= '0;
        end else begin
            tick_cnt <= wrap ? '0 : tick_cnt + 1'b1;
            if (wrap) digit_sel <= digit_sel + 1'b1;
        end
    end
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: digit scan plus a one-deep pending word applied only at frame boundaries.
// Optional PWM dimming via SSEG_SCAN_DIM_EN (adds duty input, drives blank).
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int TICKS = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_hex_dec,
    input  logic        in_sign,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] data,
    output logic        hex_dec,
    output logic        sign,
    output digit_sel_t  digit_sel,
    output logic        frame_start,
`ifdef SSEG_SCAN_DIM_EN
    input  logic [4:0]  duty,
`endif
    output logic        blank
);
    disp_word_t pend, disp;
    logic pend_full, fb, wrap_unused;

    refresh_counter #(.TICKS(TICKS)) u_cnt (
        .clk(clk),
        .rst_n(rst_n),
        .digit_sel(digit_sel),
        .wrap(wrap_unused),
        .fb(fb)
    );

    assign in_ready = ~pend_full;
    assign data = disp.data;
    assign hex_dec = disp.hex_dec;
    assign sign = disp.sign;

    // apply has priority; at fb with a pending word in_ready is low, so no accept collides
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            disp        <= '0;
            pend_full   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= fb;
            if (fb && pend_full) begin
                disp      <= pend;
                pend_full <= 1'b0;
            end else if (in_valid && in_ready) begin
                pend      <= '{data: in_data, hex_dec: in_hex_dec, sign: in_sign};
                pend_full <= 1'b1;
            end
        end
    end

`ifdef SSEG_SCAN_DIM_EN
    logic [3:0] pwm_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            blank   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            blank   <= {1'b0, pwm_cnt} >= duty;
        end
    end
`else
    assign blank = 1'b0;
`endif
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: directed checks of scan, handshake, frame-boundary apply and async reset (TICKS=4).
module tb_sseg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_hex_dec = 1'b0;
    logic        in_sign = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready, hex_dec, sign, frame_start, blank;
    logic [15:0] data;
    logic [1:0]  digit_sel;
`ifdef SSEG_SCAN_DIM_EN
    logic [4:0]  duty = '0;
`endif
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.TICKS(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_hex_dec(in_hex_dec),
        .in_sign(in_sign),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data(data),
        .hex_dec(hex_dec),
        .sign(sign),
        .digit_sel(digit_sel),
        .frame_start(frame_start),
`ifdef SSEG_SCAN_DIM_EN
        .duty(duty),
`endif
        .blank(blank)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) adv(1);
    endtask

    task automatic offer(input logic [15:0] d, input logic h, input logic s);
        in_data = d;
        in_hex_dec = h;
        in_sign = s;
        in_valid = 1'b1;
    endtask

    initial begin
        #2;
        chk("rst_data", data, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_sel", digit_sel, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_blank", blank, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        // scan: state after cyc edges has digit_sel = (cyc/4)%4, frame_start on cyc%16==0 after the first frame
        while (cyc < 36) begin
            chk("scan_sel", digit_sel, (cyc / 4) % 4);
            chk("scan_fs", frame_start, (cyc % 16 == 0 && cyc >= 16) ? 1 : 0);
            chk("scan_data", data, 0);
            adv(1);
        end
        // single update while digit_sel==1
        chk("upd_sel1", digit_sel, 1);
        offer(16'h1234, 1'b1, 1'b0);
        adv(1);
        in_valid = 1'b0;
        chk("upd_ready_lo", in_ready, 0);
        chk("upd_data_old", data, 0);
        run_to(47);
        chk("upd_fb_data", data, 0);
        chk("upd_fb_sel", digit_sel, 3);
        adv(1);
        chk("upd_data", data, 16'h1234);
        chk("upd_hex", hex_dec, 1);
        chk("upd_sign", sign, 0);
        chk("upd_sel0", digit_sel, 0);
        chk("upd_fs", frame_start, 1);
        chk("upd_ready_hi", in_ready, 1);
        // backpressure
        offer(16'hAAAA, 1'b0, 1'b1);
        adv(1);
        offer(16'h5555, 1'b1, 1'b0);
        chk("bp_ready_lo", in_ready, 0);
        run_to(63);
        chk("bp_old", data, 16'h1234);
        adv(1);
        chk("bp_a", data, 16'hAAAA);
        chk("bp_a_sign", sign, 1);
        chk("bp_a_hex", hex_dec, 0);
        chk("bp_ready_hi", in_ready, 1);
        adv(1);
        in_valid = 1'b0;
        chk("bp_b_taken", in_ready, 0);
        run_to(79);
        chk("bp_a_held", data, 16'hAAAA);
        adv(1);
        chk("bp_b", data, 16'h5555);
        // accept in the fb cycle
        run_to(95);
        chk("fb_sel", digit_sel, 3);
        offer(16'h00FF, 1'b1, 1'b0);
        adv(1);
        in_valid = 1'b0;
        chk("fb_not_yet", data, 16'h5555);
        chk("fb_pending", in_ready, 0);
        run_to(111);
        chk("fb_held", data, 16'h5555);
        adv(1);
        chk("fb_applied", data, 16'h00FF);
        chk("fb_hex", hex_dec, 1);
        // async reset mid-frame with a word pending
        run_to(120);
        chk("ar_sel2", digit_sel, 2);
        offer(16'hBEEF, 1'b0, 1'b1);
        adv(1);
        in_valid = 1'b0;
        chk("ar_pending", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_data", data, 0);
        chk("ar_hex", hex_dec, 0);
        chk("ar_sign", sign, 0);
        chk("ar_sel", digit_sel, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_fs", frame_start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        run_to(16);
        chk("ar_fs_frame", frame_start, 1);
        chk("ar_discard", data, 0);
        run_to(32);
        chk("ar_discard2", data, 0);
        chk("ar_ready2", in_ready, 1);
`ifdef SSEG_SCAN_DIM_EN
        begin
            int cnt;
            logic [4:0] duties [4] = '{5'd0, 5'd4, 5'd8, 5'd16};
            int exp_cnt [4] = '{16, 12, 8, 0};
            for (int k = 0; k < 4; k++) begin
                duty = duties[k];
                adv(2);
                cnt = 0;
                for (int j = 0; j < 16; j++) begin
                    cnt += int'(blank);
                    adv(1);
                end
                chk("dim_blank_count", cnt, exp_cnt[k]);
            end
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
